// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester arbiter controller.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;

    // Binary requester index
    typedef logic [1:0] arb_idx_t;

    // Controller FSM states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Rotate a request vector so that bit j holds vec[(j + base) mod 4].
    // With base = last granted index, bit 3 then holds (base-1), bit 0 holds base,
    // so a fixed "bit 3 wins" encoder yields the descending round-robin order.
    function automatic logic [NUM_REQ-1:0] rotate_req(input logic [NUM_REQ-1:0] vec,
                                                      input arb_idx_t base);
        logic [NUM_REQ-1:0] rot;
        rot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            arb_idx_t src;
            src = arb_idx_t'(j) + base;
            rot[j] = vec[src];
        end
        return rot;
    endfunction

    // Binary index to one-hot grant vector
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input arb_idx_t idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Combinational 4-to-2 priority encoder, bit 3 highest, with an all-zero flag.
module arb_prio_enc
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_vec,
    output logic [1:0]         idx,
    output logic               zero
);

    // Highest set bit wins; idx is 0 when nothing is set
    always_comb begin
        idx  = 2'd0;
        zero = 1'b0;
        if (req_vec[3]) begin
            idx = 2'd3;
        end else if (req_vec[2]) begin
            idx = 2'd2;
        end else if (req_vec[1]) begin
            idx = 2'd1;
        end else if (req_vec[0]) begin
            idx = 2'd0;
        end else begin
            zero = 1'b1;
        end
    end

endmodule

// File: rtl/arb_4req_ctrl.sv
// Four-requester arbiter controller with bounded grant length and timeout masking.
// Fixed priority (req[3] highest) by default; define ARB_ROUND_ROBIN_EN to rotate
// the search order after every new grant.
module arb_4req_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16  // legal range 2..256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_id,
    output logic               gnt_vld,
    output logic               tmo,
    output logic               idle
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    arb_idx_t           gnt_id_q, gnt_id_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic               tmo_q, tmo_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] elig_rot;
    arb_idx_t           rot_base;
    arb_idx_t           enc_idx;
    logic               enc_zero;
    arb_idx_t           win_idx;
    logic               grant_new;

    assign elig = req & ~mask_q;

`ifdef ARB_ROUND_ROBIN_EN
    arb_idx_t ptr_q, ptr_d;

    assign rot_base = ptr_q;
    assign ptr_d    = grant_new ? win_idx : ptr_q;

    // Round-robin pointer remembers the last newly granted index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign rot_base = 2'd0;
`endif

    assign elig_rot = rotate_req(elig, rot_base);

    arb_prio_enc u_prio_enc (
        .req_vec (elig_rot),
        .idx     (enc_idx),
        .zero    (enc_zero)
    );

    // Undo the rotation to recover the true requester index
    assign win_idx   = enc_idx + rot_base;
    assign grant_new = (state_q == IDLE) && !enc_zero;

    // Next-state: arbitration in IDLE, hold/release/timeout in GRANT
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_vld_d  = gnt_vld_q;
        tmo_d      = 1'b0;
        hold_cnt_d = hold_cnt_q;
        // A mask bit survives only while its request stays high
        mask_d     = mask_q & req;

        unique case (state_q)
            IDLE: begin
                if (grant_new) begin
                    state_d    = GRANT;
                    gnt_d      = idx_to_onehot(win_idx);
                    gnt_id_d   = win_idx;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    // Normal release wins over a coincident timeout
                    state_d    = IDLE;
                    gnt_d      = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d          = IDLE;
                    gnt_d            = '0;
                    gnt_vld_d        = 1'b0;
                    hold_cnt_d       = '0;
                    tmo_d            = 1'b1;
                    mask_d[gnt_id_q] = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= 2'd0;
            gnt_vld_q  <= 1'b0;
            tmo_q      <= 1'b0;
            hold_cnt_q <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            tmo_q      <= tmo_d;
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign tmo     = tmo_q;
    assign idle    = (state_q == IDLE) && enc_zero;

    // Output invariants
    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_vld_match  : assert property (@(posedge clk) disable iff (rst) gnt_vld == (gnt != '0));
    a_tmo_no_gnt : assert property (@(posedge clk) disable iff (rst) tmo |-> !gnt_vld);

endmodule

// File: tb/tb_arb_4req_ctrl.sv
// Self-checking bench for arb_4req_ctrl: directed scenarios plus random requests,
// all compared against a behavioural model of the arbitration rules.
module tb_arb_4req_ctrl;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       tmo;
    logic       idle;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: owner index (-1 = none), cycles granted, masks, last id
    int         m_owner = -1;
    int         m_hold  = 0;
    logic [3:0] m_mask  = 4'b0000;
    int         m_last  = 0;
    logic       m_tmo   = 1'b0;
    int         m_ptr   = 0;

    arb_4req_ctrl #(
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .tmo     (tmo),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_mask  = 4'b0000;
        m_last  = 0;
        m_tmo   = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock of arbitration rules applied to the sampled request vector
    task automatic model_step(input logic [3:0] r);
        logic [3:0] elig;
        logic [3:0] nmask;
        elig  = r & ~m_mask;
        nmask = m_mask & r;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            // Search order: ptr-1, ptr-2, ptr-3, ptr (mod 4); ptr stays 0 in fixed mode
            for (int s = 1; s <= 4; s++) begin
                int c;
                c = (m_ptr - s + 8) % 4;
                if (elig[c]) begin
                    m_owner = c;
                    m_hold  = 0;
                    m_last  = c;
`ifdef ARB_ROUND_ROBIN_EN
                    m_ptr   = c;
`endif
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_hold == MAX_HOLD - 1) begin
            nmask[m_owner] = 1'b1;
            m_tmo   = 1'b1;
            m_owner = -1;
        end else begin
            m_hold++;
        end
        m_mask = nmask;
    endtask

    // Model advances on every clock edge and on reset assertion
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step(req);
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial begin
        forever begin
            logic [3:0] exp_gnt;
            logic       exp_idle;
            @(posedge clk);
            #1;
            exp_gnt = 4'b0000;
            if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
            exp_idle = (m_owner < 0) && ((req & ~m_mask) == 4'b0000);
            chk("cyc_gnt", 32'(gnt), 32'(exp_gnt));
            chk("cyc_gnt_id", 32'(gnt_id), 32'(m_last));
            chk("cyc_gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
            chk("cyc_tmo", 32'(tmo), 32'(m_tmo));
            chk("cyc_idle", 32'(idle), 32'(exp_idle));
        end
    end

    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt_vld && n < 20);
        if (!gnt_vld) begin
            checks++;
            failures++;
            $display("FAIL %s: gnt_vld=0 after 20 cycles, expected 1", name);
        end
    endtask

    initial begin
        int exp_ids[5];
        int cnt;
`ifdef ARB_ROUND_ROBIN_EN
        exp_ids = '{3, 2, 1, 0, 3};
`else
        exp_ids = '{3, 3, 3, 3, 3};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_vld", 32'(gnt_vld), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        rst = 1'b0;

        // Single requester, one-cycle latency, release to idle
        req = 4'b0100;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_id", 32'(gnt_id), 32'h2);
        req = 4'b0000;
        @(negedge clk);
        chk("single_rel_gnt", 32'(gnt), 32'h0);
        chk("single_rel_idle", 32'(idle), 32'h1);
        chk("single_rel_id_hold", 32'(gnt_id), 32'h2);

        // All requesting; owner drops for one cycle after 3 grant cycles
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            logic [3:0] drop;
            wait_gnt("all_wait");
            chk("all_order", 32'(gnt_id), 32'(exp_ids[g]));
            repeat (2) @(negedge clk);
            drop = 4'b0000;
            drop[gnt_id] = 1'b1;
            req = 4'b1111 & ~drop;
            @(negedge clk);
            chk("all_dead", 32'(gnt), 32'h0);
            req = 4'b1111;
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Timeout: exactly MAX_HOLD grant cycles, one tmo pulse, masked until req drops
        req = 4'b0001;
        wait_gnt("tmo_wait");
        cnt = 0;
        while (gnt == 4'b0001 && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_len", 32'(cnt), 32'(MAX_HOLD));
        chk("tmo_pulse", 32'(tmo), 32'h1);
        chk("tmo_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("tmo_once", 32'(tmo), 32'h0);
        repeat (2) @(negedge clk);
        chk("tmo_masked_vld", 32'(gnt_vld), 32'h0);
        chk("tmo_masked_idle", 32'(idle), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0001;
        wait_gnt("tmo_regrant");
        chk("tmo_regrant_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Release coinciding with the last hold cycle is a normal release
        req = 4'b0100;
        wait_gnt("edge_wait");
        repeat (3) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        chk("edge_tmo", 32'(tmo), 32'h0);
        chk("edge_gnt", 32'(gnt), 32'h0);
        req = 4'b0100;
        @(negedge clk);
        chk("edge_unmasked", 32'(gnt), 32'h4);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // No preemption by a higher-priority request
        req = 4'b0010;
        wait_gnt("np_wait");
        req = 4'b1010;
        @(negedge clk);
        chk("np_hold1", 32'(gnt), 32'h2);
        @(negedge clk);
        chk("np_hold2", 32'(gnt), 32'h2);
        req = 4'b1000;
        @(negedge clk);
        chk("np_dead", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("np_next", 32'(gnt), 32'h8);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-grant
        req = 4'b0100;
        wait_gnt("ar_wait");
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_vld", 32'(gnt_vld), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        chk("ar_after_gnt", 32'(gnt), 32'h8);
        chk("ar_after_id", 32'(gnt_id), 32'h3);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Random request traffic; each bit flips with probability 1/6 per cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) req[b] = ~req[b];
            end
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
